sdram_burst_responder: RTL and testbench
========================================

// Module: sdram_burst_responder
// PURPOSE
//  Slave end of the cache line-fill interface (sdram_req/sdram_addr/sdram_fill/data). Accepts one
//  line request from a direct-mapped cache and fetches the 8-word line critical-word-first from a
//  word-wide, variable-latency memory port. It buffers the whole line, then streams it to the cache
//  on 8 consecutive cycles, with sdram_fill marking the first beat. Sits between cache and SDRAM/ROM.
// PARAMETERS
//  holdfill  0  0: sdram_fill high on beat 0 only; 1: sdram_fill high on all 8 beats
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  reset        in   1   asynchronous, active-low reset
//  sdram_addr   in   32  byte address of requested word from cache; [31:5]=line, [4:2]=critical word
//  sdram_req    in   1   line request from cache; level, sampled in IDLE
//  sdram_fill   out  1   registered; marks first beat of line stream (all beats if holdfill=1)
//  fill_data    out  32  registered line word, to cache data_from_sdram
//  busy         out  1   registered; high in every state except IDLE
//  mem_addr     out  32  word address to memory; {line,ptr,2'b00}
//  mem_req      out  1   memory read request; held with stable mem_addr until mem_ack
//  mem_ack      in   1   memory accepted the read; mem_data valid in same cycle
//  mem_data     in   32  read data, valid when mem_ack=1
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, sdram_fill=0, fill_data=0, busy=0, mem_req=0,
//   mem_addr=0, ptr=0, cnt=0. Line buffer contents are not cleared. Partial fetch/stream is
//   abandoned, and mem_req drops immediately.
//  Registers: line[26:0], crit[2:0], ptr[2:0] (mod-8 wrap), cnt[3:0], buf[0:7] of 32 bits.
//  IDLE: busy=0. If sdram_req=1: latch line=sdram_addr[31:5], crit=ptr=sdram_addr[4:2], cnt=0.
//   Next state is FETCH, and mem_req=1 with mem_addr={sdram_addr[31:5],sdram_addr[4:2],2'b00}.
//  FETCH: mem_req=1. On a cycle with mem_ack=1: buf[cnt]<=mem_data, cnt<=cnt+1, ptr<=ptr+1.
//   mem_addr then updates to the new ptr. If cnt==7 at the ack, mem_req<=0 and go to STREAM.
//   With mem_ack=0, mem_req and mem_addr hold.
//   At most one read is outstanding. mem_ack may be high the first cycle mem_req is high.
//   Word order: crit, crit+1, ..., crit+7, all mod 8 and all within the line.
//  STREAM: 8 cycles, beats k=0..7: fill_data=buf[k], sdram_fill=(k==0)|holdfill.
//   Beats are contiguous with no gaps; the cache consumes one word per cycle after the fill pulse.
//   After beat 7: sdram_fill=0, fill_data holds, go to DONE.
//  DONE: if sdram_req=0 go to IDLE; otherwise wait. This prevents retriggering on a stale request,
//   because the cache drops req registered on the fill cycle.
//  sdram_req deasserted during FETCH/STREAM is ignored; the line always completes.
//  sdram_addr changes after the IDLE latch are ignored.
//  Latency: req sampled in IDLE at cycle T; mem_req first high at T+1.
//   Last ack at cycle A gives the first beat (sdram_fill=1) at A+1 and the last beat at A+8.
//   Minimum (ack every cycle) is fill at T+9 and the last beat at T+16.
//  cnt is 4 bits so the 8th ack is detectable; ptr wraps 7->0 naturally.
// TESTING
//  1 Req addr 0x00001234, mem_data=mem_addr, ack every cycle -> mem_addr 0x1234,0x1238,0x123C,
//    0x1220..0x1230. sdram_fill one cycle at T+9, fill_data same sequence on 8 consecutive beats.
//  2 Req 0x00000040 (crit=0), random 0-5 wait states per ack -> mem_addr 0x40..0x5C ascending.
//    Stream still 8 gapless beats starting the cycle after the last ack; no extra mem_req.
//  3 Reset low after 3rd ack in FETCH -> mem_req, busy, sdram_fill=0 immediately.
//    After reset release, req 0x1234 fetches all 8 words again from 0x1234.
//  4 Hold sdram_req=1 through stream -> stays DONE (busy=1), no new mem_req.
//    Drop req 1 cycle then raise -> one new fetch.
//  5 holdfill=1, req 0x00000010 -> sdram_fill high exactly 8 cycles, fill_data 0x10,0x14,0x18,
//    0x1C,0x00,0x04,0x08,0x0C.
//  6 mem_ack high on first mem_req cycle, and sdram_addr changed during FETCH ->
//    captured word correct, line address unaffected.

Source files
------------

// File: rtl/sdram_burst_responder.sv
// Cache line-fill responder: fetches an 8-word line critical-word-first from a
// variable-latency word memory, buffers it, then streams it to the cache on 8 gapless beats.
module sdram_burst_responder #(
   parameter bit holdfill = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] sdram_addr,
   input  logic        sdram_req,
   output logic        sdram_fill,
   output logic [31:0] fill_data,
   output logic        busy,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [31:0] mem_data
);

   typedef enum logic [1:0] {StIdle, StFetch, StStream, StDone} state_e;

   state_e      state_q, state_d;
   logic [26:0] line_q;
   logic [2:0]  ptr_q;
   logic [3:0]  cnt_q;
   logic [31:0] line_buf [8];

   // Byte-offset bits of the request address carry no information for a word fetch.
   logic unused_addr_bits;
   assign unused_addr_bits = ^sdram_addr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (sdram_req) state_d = StFetch;
         StFetch:  if (mem_ack && cnt_q == 4'd7) state_d = StStream;
         StStream: if (cnt_q == 4'd8) state_d = StDone;
         StDone:   if (!sdram_req) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Line buffer is deliberately not reset; it is always fully rewritten before streaming.
   always_ff @(posedge clk) begin
      if (state_q == StFetch && mem_ack) begin
         line_buf[cnt_q[2:0]] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sdram_fill <= 1'b0;
         fill_data  <= 32'd0;
         busy       <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= 32'd0;
         line_q     <= 27'd0;
         ptr_q      <= 3'd0;
         cnt_q      <= 4'd0;
      end else begin
         busy <= (state_d != StIdle);
         case (state_q)
            StIdle: begin
               if (sdram_req) begin
                  line_q   <= sdram_addr[31:5];
                  ptr_q    <= sdram_addr[4:2];
                  cnt_q    <= 4'd0;
                  mem_req  <= 1'b1;
                  mem_addr <= {sdram_addr[31:2], 2'b00};
               end
            end
            StFetch: begin
               if (mem_ack) begin
                  ptr_q    <= ptr_q + 3'd1;
                  mem_addr <= {line_q, ptr_q + 3'd1, 2'b00};
                  if (cnt_q == 4'd7) begin
                     // Last word lands now; beat 0 is presented on the very next cycle.
                     mem_req    <= 1'b0;
                     cnt_q      <= 4'd1;
                     fill_data  <= line_buf[0];
                     sdram_fill <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            StStream: begin
               // cnt_q holds the index of the next beat; 8 means beat 7 is on the bus.
               if (cnt_q == 4'd8) begin
                  sdram_fill <= 1'b0;
               end else begin
                  fill_data  <= line_buf[cnt_q[2:0]];
                  sdram_fill <= holdfill;
                  cnt_q      <= cnt_q + 4'd1;
               end
            end
            StDone: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Scoreboard bench: two responders (holdfill 0 and 1) share stimulus and a memory model;
// expected fetch addresses and stream words are queued at issue time and checked by monitors.
module tb_sdram_burst_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] sdram_addr = 32'd0;
   logic        sdram_req = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_data;

   logic        sdram_fill, busy, mem_req;
   logic [31:0] fill_data, mem_addr;
   logic        sdram_fill_h, busy_h, mem_req_h;
   logic [31:0] fill_data_h, mem_addr_h;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];

   int          max_wait = 0;
   int          wait_left = 0;
   int          ack_count = 0;
   int          last_ack_cyc = 0;
   int          first_fill_cyc = 0;
   int          req_cyc = 0;
   int          beat = 0;
   bit          active = 1'b0;
   bit          post = 1'b0;
   logic [31:0] last_word = 32'd0;

   assign mem_data = mem_addr;

   sdram_burst_responder #(.holdfill(1'b0)) dut (
      .clk       (clk),
      .reset     (reset),
      .sdram_addr(sdram_addr),
      .sdram_req (sdram_req),
      .sdram_fill(sdram_fill),
      .fill_data (fill_data),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .mem_data  (mem_data)
   );

   sdram_burst_responder #(.holdfill(1'b1)) dut_h (
      .clk       (clk),
      .reset     (reset),
      .sdram_addr(sdram_addr),
      .sdram_req (sdram_req),
      .sdram_fill(sdram_fill_h),
      .fill_data (fill_data_h),
      .busy      (busy_h),
      .mem_addr  (mem_addr_h),
      .mem_req   (mem_req_h),
      .mem_ack   (mem_ack),
      .mem_data  (mem_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic gen_line(input logic [31:0] a, output logic [31:0] ev [8]);
      logic [2:0] w;
      for (int i = 0; i < 8; i++) begin
         w = a[4:2] + 3'(i);
         ev[i] = {a[31:5], w, 2'b00};
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] ev [8], input bit hold,
                        input logic [31:0] late_addr);
      for (int i = 0; i < 8; i++) begin
         addr_q.push_back(ev[i]);
         data_q.push_back(ev[i]);
      end
      @(negedge clk);
      sdram_addr = a;
      sdram_req  = 1'b1;
      req_cyc    = cyc;
      if (!hold) begin
         @(negedge clk);
         sdram_req = 1'b0;
      end
      @(negedge clk);
      sdram_addr = late_addr;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((data_q.size() != 0 || active || post) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_in_budget", 32'(n < budget), 32'd1);
   endtask

   // Memory model: acks after a programmable number of wait states, checks each fetch address.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (reset && mem_req) begin
            if (addr_q.size() == 0) begin
               check("unexpected_mem_req", 32'(mem_req), 32'd0);
            end else if (wait_left > 0) begin
               wait_left--;
            end else begin
               mem_ack = 1'b1;
               ack_count++;
               last_ack_cyc = cyc;
               e = addr_q.pop_front();
               check("mem_addr", mem_addr, e);
               check("mem_addr_h", mem_addr_h, e);
               check("mem_req_h", 32'(mem_req_h), 32'd1);
               wait_left = int'($urandom_range(0, max_wait));
            end
         end
      end
   end

   // Stream monitor: pops one expected word per beat once sdram_fill marks beat 0.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            beat = 0;
            active = 1'b0;
            post = 1'b0;
         end else begin
            if (post) begin
               check("fill_after_stream", 32'(sdram_fill), 32'd0);
               check("fill_h_after_stream", 32'(sdram_fill_h), 32'd0);
               check("fill_data_hold", fill_data, last_word);
               post = 1'b0;
            end else if (!active && sdram_fill) begin
               check("fill_after_last_ack", 32'(cyc - last_ack_cyc), 32'd1);
               first_fill_cyc = cyc;
               active = 1'b1;
               beat = 0;
            end
            if (active) begin
               if (data_q.size() == 0) begin
                  check("unexpected_stream", 32'(sdram_fill), 32'd0);
                  active = 1'b0;
               end else begin
                  e = data_q.pop_front();
                  check("fill_data", fill_data, e);
                  check("fill_data_h", fill_data_h, e);
                  check("sdram_fill", 32'(sdram_fill), 32'(beat == 0));
                  check("sdram_fill_h", 32'(sdram_fill_h), 32'd1);
                  beat++;
                  if (beat == 8) begin
                     active = 1'b0;
                     post = 1'b1;
                     last_word = e;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t1 [8];
      logic [31:0] t5 [8];
      logic [31:0] ev [8];
      int base;
      t1 = '{32'h1234, 32'h1238, 32'h123C, 32'h1220, 32'h1224, 32'h1228, 32'h122C, 32'h1230};
      t5 = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C};

      // Reset state
      #23;
      check("rst_fill", 32'(sdram_fill), 32'd0);
      check("rst_fill_data", fill_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_busy_h", 32'(busy_h), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: critical word 5, ack every cycle, minimum latency
      max_wait = 0;
      wait_left = 0;
      issue(32'h0000_1234, t1, 1'b0, 32'h0000_1234);
      wait_done(100);
      check("t1_fill_latency", 32'(first_fill_cyc - req_cyc), 32'd9);
      repeat (3) @(negedge clk);
      check("t1_idle_busy", 32'(busy), 32'd0);

      // 2: critical word 0 with random wait states
      max_wait = 5;
      gen_line(32'h0000_0040, ev);
      issue(32'h0000_0040, ev, 1'b0, 32'h0000_0040);
      wait_done(200);
      repeat (3) @(negedge clk);
      check("t2_idle_busy", 32'(busy), 32'd0);

      // 3: reset after the third ack, then a full refetch
      max_wait = 0;
      wait_left = 0;
      base = ack_count;
      issue(32'h0000_1234, t1, 1'b0, 32'h0000_1234);
      wait (ack_count >= base + 3);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("t3_mem_req", 32'(mem_req), 32'd0);
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_fill", 32'(sdram_fill), 32'd0);
      addr_q.delete();
      data_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_left = 0;
      @(negedge clk);
      issue(32'h0000_1234, t1, 1'b0, 32'h0000_1234);
      wait_done(100);
      repeat (3) @(negedge clk);

      // 4: request held through the stream parks in DONE, then one refetch
      gen_line(32'h0000_2468, ev);
      issue(32'h0000_2468, ev, 1'b1, 32'h0000_2468);
      wait_done(100);
      repeat (5) @(negedge clk);
      check("t4_done_busy", 32'(busy), 32'd1);
      check("t4_done_mem_req", 32'(mem_req), 32'd0);
      sdram_req = 1'b0;
      @(negedge clk);
      issue(32'h0000_2468, ev, 1'b1, 32'h0000_2468);
      wait_done(100);
      sdram_req = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_idle_busy", 32'(busy), 32'd0);

      // 5: hand-computed wrap from critical word 4; holdfill checked on dut_h every beat
      issue(32'h0000_0010, t5, 1'b0, 32'h0000_0010);
      wait_done(100);
      repeat (3) @(negedge clk);

      // 6: ack on first mem_req cycle and request address scrambled during fetch
      gen_line(32'hDEAD_BEEC, ev);
      issue(32'hDEAD_BEEC, ev, 1'b0, 32'h1357_9BDC);
      wait_done(100);
      repeat (3) @(negedge clk);
      check("t6_idle_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
